poly_tone_generator: RTL and testbench

- Multi-channel successor to the single-channel square-wave tone generator.
- Each of NUM_CH channels has three per-channel settings:
  - a programmable period;
  - a duty (high-time) count;
  - a note duration counted in external ticks.
- Outputs: per-channel square waves plus a registered mix count. The mix count feeds the audio PWM/DAC stage. Channels are loaded by the note sequencer through a single write port.

---
 rtl/poly_tone_generator.sv | 119 +++++++++++
 tb/tb_poly_tone_generator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_generator.sv
// Multi-channel square-wave tone generator: per-channel period/duty/duration,
// shared write port, registered square outputs and a popcount mix.
module poly_tone_generator #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 24,
  parameter int DUR_W    = 16,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MIX_W    = $clog2(NUM_CH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                global_enable,
  input  logic                tick,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [PERIOD_W-1:0] wr_duty,
  input  logic [DUR_W-1:0]    wr_dur,
  output logic [NUM_CH-1:0]   square_out,
  output logic [MIX_W-1:0]    mix_out,
  output logic [NUM_CH-1:0]   active,
  output logic [NUM_CH-1:0]   done_pulse
);

  logic [NUM_CH-1:0] square_d;
  logic [NUM_CH-1:0] done_d;
  logic [NUM_CH-1:0] active_q;
  logic [MIX_W-1:0]  mix_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] duty_q, duty_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                act_q, act_d;
    logic                done_ch_d;
    logic                wr_hit;

    // Indices beyond NUM_CH-1 match no channel, so such writes fall through.
    assign wr_hit = wr_en && (wr_ch == CH_W'(gi));

    always_comb begin
      period_d  = period_q;
      duty_d    = duty_q;
      cnt_d     = cnt_q;
      dur_d     = dur_q;
      act_d     = act_q;
      done_ch_d = 1'b0;
      if (wr_hit) begin
        period_d = wr_period;
        duty_d   = wr_duty;
        dur_d    = wr_dur;
        cnt_d    = '0;
        act_d    = (wr_dur != '0);
      end else if (global_enable && act_q) begin
        if (period_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
        // All-ones duration never counts down: the note plays until rewritten.
        if (tick && (dur_q != '1)) begin
          if (dur_q == DUR_W'(1)) begin
            dur_d     = '0;
            act_d     = 1'b0;
            done_ch_d = 1'b1;
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        period_q <= '0;
        duty_q   <= '0;
        cnt_q    <= '0;
        dur_q    <= '0;
        act_q    <= 1'b0;
      end else begin
        period_q <= period_d;
        duty_q   <= duty_d;
        cnt_q    <= cnt_d;
        dur_q    <= dur_d;
        act_q    <= act_d;
      end
    end

    assign square_d[gi] = global_enable & act_q & (period_q != '0) & (cnt_q < duty_q);
    assign done_d[gi]   = done_ch_d;
    assign active_q[gi] = act_q;
  end

  // Mix is the popcount of the next square value so both registers always agree.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_d = mix_d + MIX_W'(square_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      square_out <= '0;
      mix_out    <= '0;
      done_pulse <= '0;
    end else begin
      square_out <= square_d;
      mix_out    <= mix_d;
      done_pulse <= done_d;
    end
  end

  assign active = active_q;

endmodule

// File: tb/tb_poly_tone_generator.sv
// Randomised and directed bench for poly_tone_generator, checked every cycle
// against a phase-count/tick-count reference model.
module tb_poly_tone_generator;
  localparam int NCH = 3;
  localparam int PW  = 24;
  localparam int DW  = 16;
  localparam int CHW = 2;
  localparam int MW  = 2;
  localparam int INF = 65535;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ge = 1'b0;
  logic           tick = 1'b0;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [PW-1:0]  wr_period = '0;
  logic [PW-1:0]  wr_duty = '0;
  logic [DW-1:0]  wr_dur = '0;
  logic [NCH-1:0] square_out, active, done_pulse;
  logic [MW-1:0]  mix_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  poly_tone_generator #(
    .NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .global_enable(ge), .tick(tick),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period), .wr_duty(wr_duty),
    .wr_dur(wr_dur), .square_out(square_out), .mix_out(mix_out),
    .active(active), .done_pulse(done_pulse)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: phase is simply (enabled playing cycles since load) mod period,
  // and a note ends when the number of counted ticks reaches its duration.
  int m_per[NCH], m_duty[NCH], m_dur[NCH], m_n[NCH], m_ticks[NCH];
  bit m_act[NCH];
  logic [NCH-1:0] e_sq, e_done, e_act;
  logic [MW-1:0]  e_mix;
  int pop;

  always @(posedge clk) begin
    e_done = '0;
    e_sq   = '0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = 0; m_duty[c] = 0; m_dur[c] = 0;
        m_n[c] = 0; m_ticks[c] = 0; m_act[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ge && m_act[c] && m_per[c] != 0)
          e_sq[c] = (m_n[c] % m_per[c]) < m_duty[c];
        if (wr_en && int'(wr_ch) == c) begin
          m_per[c]  = int'(wr_period);
          m_duty[c] = int'(wr_duty);
          m_dur[c]  = int'(wr_dur);
          m_n[c]    = 0;
          m_ticks[c] = 0;
          m_act[c]  = (wr_dur != '0);
        end else if (ge && m_act[c]) begin
          m_n[c]++;
          if (tick && m_dur[c] != INF) begin
            m_ticks[c]++;
            if (m_ticks[c] == m_dur[c]) begin
              m_act[c]  = 1'b0;
              e_done[c] = 1'b1;
            end
          end
        end
      end
    end
    pop = 0;
    for (int c = 0; c < NCH; c++) begin
      pop += int'(e_sq[c]);
      e_act[c] = m_act[c];
    end
    e_mix = MW'(pop);
    #1;
    chk("square_out", square_out, e_sq);
    chk("mix_out", mix_out, e_mix);
    chk("active", active, e_act);
    chk("done_pulse", done_pulse, e_done);
    chk("mix_popcount", mix_out, $countones(square_out));
  end

  task automatic wr(input int ch, input int per, input int duty, input int dur);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_period = PW'(per);
    wr_duty = PW'(duty); wr_dur = DW'(dur);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cap_sq(input int ch, input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bits = {bits[30:0], square_out[ch]};
    end
  endtask

  logic [31:0]    bits;
  logic [NCH-1:0] prev_act;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0; ge = 1'b1;

    // 10-cycle period, 5 high: high on the first edge after the load.
    wr(0, 10, 5, INF);
    cap_sq(0, 10, bits); chk("t1_wave", bits, 32'h3E0);
    cap_sq(0, 10, bits); chk("t1_wave_repeat", bits, 32'h3E0);

    // Finite note of 3 ticks.
    wr(1, 8, 2, 3);
    cap_sq(1, 8, bits); chk("t2_wave", bits, 32'hC0);
    for (int k = 0; k < 3; k++) begin
      repeat (19) @(negedge clk);
      tick = 1'b1;
      @(posedge clk); #1;
      if (k == 2) begin
        chk("t2_done", done_pulse[1], 1);
        chk("t2_inactive", active[1], 0);
      end else begin
        chk("t2_still_active", active[1], 1);
      end
      @(negedge clk); tick = 1'b0;
    end
    @(posedge clk); #1; chk("t2_done_one_cycle", done_pulse[1], 0);
    cap_sq(1, 8, bits); chk("t2_silent_after", bits, 32'h0);

    // Duty/period edge cases.
    wr(2, 10, 0, INF);  cap_sq(2, 10, bits); chk("t3_duty0", bits, 32'h0);
    wr(2, 10, 12, INF); cap_sq(2, 10, bits); chk("t3_duty_gt", bits, 32'h3FF);
    wr(2, 0, 5, INF);   cap_sq(2, 10, bits); chk("t3_period0", bits, 32'h0);

    // Two channels mixed.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    wr(0, 4, 2, INF);
    wr(2, 4, 4, INF);
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bits = {bits[29:0], mix_out};
    end
    chk("t4_mix_seq", bits, 32'h5A);

    // Freeze with a tick inside the window; the tick must not count.
    wr(1, 8, 3, 5);
    repeat (5) @(negedge clk);
    ge = 1'b0;
    @(posedge clk); #1;
    chk("t5_frozen_sq", square_out, 0);
    chk("t5_frozen_mix", mix_out, 0);
    @(negedge clk); @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    ge = 1'b1;
    chk("t5_active_kept", active[1], 1);
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(posedge clk); #1;
      if (k == 4) chk("t5_done_after_5", done_pulse[1], 1);
      else chk("t5_no_early_done", done_pulse[1], 0);
      @(negedge clk); tick = 1'b0;
    end

    // Out-of-range write index.
    prev_act = active;
    wr(3, 5, 2, 0);
    chk("t6_oob_write", active, prev_act);

    // Write coincident with the final tick: retrigger, no done.
    wr(1, 6, 3, 2);
    repeat (3) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1; wr_en = 1'b1; wr_ch = 2'd1;
    wr_period = PW'(5); wr_duty = PW'(1); wr_dur = DW'(4);
    @(posedge clk); #1;
    chk("t6_coincident_done", done_pulse[1], 0);
    chk("t6_coincident_active", active[1], 1);
    @(negedge clk); tick = 1'b0; wr_en = 1'b0;

    // Reset mid-note.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_sq", square_out, 0);
    chk("t6_rst_active", active, 0);
    chk("t6_rst_mix", mix_out, 0);
    @(negedge clk); rst = 1'b0;

    // Randomised traffic, checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 599) == 0);
      ge        = ($urandom_range(0, 7) != 0);
      tick      = ($urandom_range(0, 11) == 0);
      wr_en     = ($urandom_range(0, 14) == 0);
      wr_ch     = CHW'($urandom_range(0, 3));
      wr_period = PW'($urandom_range(0, 12));
      wr_duty   = PW'($urandom_range(0, 14));
      case ($urandom_range(0, 5))
        0: wr_dur = DW'(0);
        1: wr_dur = DW'(1);
        2: wr_dur = DW'(2);
        3: wr_dur = DW'(3);
        4: wr_dur = DW'(6);
        default: wr_dur = DW'(INF);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; tick = 1'b0; ge = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
